// File: rtl/u_pkg.sv
// Shared defaults and helpers for the writeback/forwarding pipeline.
package u_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 5;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            c = c + {3'b000, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/u_wb_fwd_pipe_if.sv
// Bus bundle between the execute stage, the writeback pipe and the register file.
interface u_wb_fwd_pipe_if
    import u_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NRP   = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                 stall;
    logic                 flush;
    logic                 in_we;
    logic [AW-1:0]        in_a;
    logic [XLEN-1:0]      in_d;
    logic                 rf_rd_e;
    logic [AW-1:0]        rf_rd_a;
    logic [XLEN-1:0]      rf_rd_i;
    logic [NRP*AW-1:0]    rd_a;
    logic [NRP*XLEN-1:0]  rf_o;
    logic [NRP*XLEN-1:0]  fwd_o;
    logic [NRP-1:0]       fwd_hit;
    logic [CW-1:0]        pend_cnt;

    modport master (
        output stall, flush, in_we, in_a, in_d, rd_a, rf_o,
        input  rf_rd_e, rf_rd_a, rf_rd_i, fwd_o, fwd_hit, pend_cnt
    );

    modport slave (
        input  stall, flush, in_we, in_a, in_d, rd_a, rf_o,
        output rf_rd_e, rf_rd_a, rf_rd_i, fwd_o, fwd_hit, pend_cnt
    );

endinterface

// File: rtl/u_fwd_sel.sv
// Single-port forwarding priority matcher: youngest matching in-flight result wins,
// falling back to the raw register-file read.
module u_fwd_sel
    import u_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned FWD_IN = 1
) (
    input  logic                  i_in_we,
    input  logic                  i_flush,
    input  logic [AW-1:0]         i_in_a,
    input  logic [XLEN-1:0]       i_in_d,
    input  logic [DEPTH-1:0]      i_e_we,
    input  logic [DEPTH*AW-1:0]   i_e_a,
    input  logic [DEPTH*XLEN-1:0] i_e_d,
    input  logic [AW-1:0]         i_rd_a,
    input  logic [XLEN-1:0]       i_rf_o,
    output logic [XLEN-1:0]       o_fwd_o,
    output logic                  o_fwd_hit
);

    // Scan oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        o_fwd_o   = i_rf_o;
        o_fwd_hit = 1'b0;
        if (i_rd_a != '0) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (i_e_we[DEPTH-1-k] && (i_e_a[(DEPTH-1-k)*AW +: AW] == i_rd_a)) begin
                    o_fwd_o   = i_e_d[(DEPTH-1-k)*XLEN +: XLEN];
                    o_fwd_hit = 1'b1;
                end
            end
            if ((FWD_IN != 0) && i_in_we && !i_flush && (i_in_a == i_rd_a)) begin
                o_fwd_o   = i_in_d;
                o_fwd_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/u_wb_fwd_pipe.sv
// Register-file writeback delay line (DEPTH entries) with per-port operand forwarding.
module u_wb_fwd_pipe
    import u_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned NRP    = 2,
    parameter int unsigned FWD_IN = 1
) (
    input logic            clk,
    input logic            rstn,
    u_wb_fwd_pipe_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } entry_t;

    entry_t                r_e [DEPTH];
    entry_t                w_e0;
    logic [CW-1:0]         r_pend;
    logic [7:0]            w_we_nxt;
    logic [DEPTH-1:0]      w_e_we;
    logic [DEPTH*AW-1:0]   w_e_a;
    logic [DEPTH*XLEN-1:0] w_e_d;
    logic [NRP*XLEN-1:0]   w_fwd_o;
    logic [NRP-1:0]        w_fwd_hit;

    // Killed or x0 results become an all-zero bubble rather than a tagged invalid entry.
    always_comb begin
        w_e0    = '0;
        w_e0.we = bus.in_we & ~bus.flush & (bus.in_a != '0);
        if (w_e0.we) begin
            w_e0.a = bus.in_a;
            w_e0.d = bus.in_d;
        end
    end

    always_comb begin
        w_we_nxt    = '0;
        w_we_nxt[0] = w_e0.we;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_we_nxt[k] = r_e[k-1].we;
        end
        w_e_we = '0;
        w_e_a  = '0;
        w_e_d  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_e_we[k]              = r_e[k].we;
            w_e_a[k*AW +: AW]      = r_e[k].a;
            w_e_d[k*XLEN +: XLEN]  = r_e[k].d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_e[k] <= '0;
            end
            r_pend <= '0;
        end else if (!bus.stall) begin
            r_e[0] <= w_e0;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_e[k] <= r_e[k-1];
            end
            r_pend <= CW'(popcount8(w_we_nxt));
        end
    end

    assign bus.rf_rd_e  = r_e[DEPTH-1].we & ~bus.stall;
    assign bus.rf_rd_a  = r_e[DEPTH-1].a;
    assign bus.rf_rd_i  = r_e[DEPTH-1].d;
    assign bus.pend_cnt = r_pend;

    for (genvar i = 0; i < NRP; i++) begin : g_port
        u_fwd_sel #(
            .XLEN   (XLEN),
            .AW     (AW),
            .DEPTH  (DEPTH),
            .FWD_IN (FWD_IN)
        ) u_sel (
            .i_in_we   (bus.in_we),
            .i_flush   (bus.flush),
            .i_in_a    (bus.in_a),
            .i_in_d    (bus.in_d),
            .i_e_we    (w_e_we),
            .i_e_a     (w_e_a),
            .i_e_d     (w_e_d),
            .i_rd_a    (bus.rd_a[i*AW +: AW]),
            .i_rf_o    (bus.rf_o[i*XLEN +: XLEN]),
            .o_fwd_o   (w_fwd_o[i*XLEN +: XLEN]),
            .o_fwd_hit (w_fwd_hit[i])
        );
    end

    assign bus.fwd_o   = w_fwd_o;
    assign bus.fwd_hit = w_fwd_hit;

endmodule

// File: tb/tb_u_wb_fwd_pipe.sv
// Directed bench for u_wb_fwd_pipe (DEPTH=3, NRP=2, FWD_IN=1).
module tb_u_wb_fwd_pipe;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    u_wb_fwd_pipe_if #(.XLEN(32), .AW(5), .DEPTH(3), .NRP(2)) bus ();

    u_wb_fwd_pipe #(
        .XLEN   (32),
        .AW     (5),
        .DEPTH  (3),
        .NRP    (2),
        .FWD_IN (1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic e, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_e"}, 32'(bus.rf_rd_e), 32'(e));
        chk({tag, "_a"}, 32'(bus.rf_rd_a), 32'(a));
        chk({tag, "_d"}, bus.rf_rd_i, d);
    endtask

    task automatic chk_fwd(input string tag, input int p, input logic [31:0] d, input logic hit);
        chk({tag, "_fwd"}, bus.fwd_o[p*32 +: 32], d);
        chk({tag, "_hit"}, 32'(bus.fwd_hit[p]), 32'(hit));
    endtask

    task automatic set_rd(input int p, input logic [4:0] a, input logic [31:0] rf);
        bus.rd_a[p*5 +: 5]  = a;
        bus.rf_o[p*32 +: 32] = rf;
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.in_we = we;
        bus.in_a  = a;
        bus.in_d  = d;
    endtask

    // Advance one cycle: inputs are updated 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        bus.rd_a = '0;
        bus.rf_o = '0;
        #3;
        chk_rf("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_pend", 32'(bus.pend_cnt), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // 1: single write to x5, latency 3
        drive(1'b1, 5'd5, 32'h1234);
        set_rd(0, 5'd5, 32'hDEAD);
        #1;
        chk_fwd("t1_in", 0, 32'h1234, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk_rf("t1_c1", 1'b0, 5'd0, 32'h0);
        chk("t1_c1_pend", 32'(bus.pend_cnt), 32'd1);
        chk_fwd("t1_c1", 0, 32'h1234, 1'b1);
        tick();
        #1;
        chk("t1_c2_e", 32'(bus.rf_rd_e), 32'd0);
        chk("t1_c2_pend", 32'(bus.pend_cnt), 32'd1);
        tick();
        #1;
        chk_rf("t1_c3", 1'b1, 5'd5, 32'h1234);
        chk("t1_c3_pend", 32'(bus.pend_cnt), 32'd1);
        tick();
        #1;
        chk("t1_c4_e", 32'(bus.rf_rd_e), 32'd0);
        chk("t1_c4_pend", 32'(bus.pend_cnt), 32'd0);
        chk_fwd("t1_c4", 0, 32'hDEAD, 1'b0);

        // 2: back-to-back x7 writes, youngest wins on both ports
        drive(1'b1, 5'd7, 32'hA);
        tick();
        drive(1'b1, 5'd7, 32'hB);
        set_rd(0, 5'd7, 32'h11);
        set_rd(1, 5'd7, 32'h55);
        #1;
        chk_fwd("t2_in_p0", 0, 32'hB, 1'b1);
        chk_fwd("t2_in_p1", 1, 32'hB, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk_fwd("t2_buf", 0, 32'hB, 1'b1);
        chk("t2_pend", 32'(bus.pend_cnt), 32'd2);
        tick();
        #1;
        chk_rf("t2_retA", 1'b1, 5'd7, 32'hA);
        chk_fwd("t2_retA", 1, 32'hB, 1'b1);
        tick();
        #1;
        chk_rf("t2_retB", 1'b1, 5'd7, 32'hB);
        chk_fwd("t2_retB", 0, 32'hB, 1'b1);
        tick();
        #1;
        chk_fwd("t2_done_p0", 0, 32'h11, 1'b0);
        chk_fwd("t2_done_p1", 1, 32'h55, 1'b0);
        chk("t2_done_pend", 32'(bus.pend_cnt), 32'd0);

        // 3: writes to x0 are dropped
        drive(1'b1, 5'd0, 32'hFFFF_FFFF);
        set_rd(0, 5'd0, 32'h77);
        #1;
        chk_fwd("t3_x0", 0, 32'h77, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk("t3_pend", 32'(bus.pend_cnt), 32'd0);
        tick();
        tick();
        #1;
        chk("t3_nowr", 32'(bus.rf_rd_e), 32'd0);

        // 4: flush kills incoming x3, older x4 still retires
        drive(1'b1, 5'd4, 32'h44);
        tick();
        drive(1'b1, 5'd3, 32'h33);
        bus.flush = 1'b1;
        set_rd(0, 5'd3, 32'h99);
        set_rd(1, 5'd4, 32'h88);
        #1;
        chk_fwd("t4_fl_p0", 0, 32'h99, 1'b0);
        chk_fwd("t4_fl_p1", 1, 32'h44, 1'b1);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk("t4_pend", 32'(bus.pend_cnt), 32'd1);
        chk_fwd("t4_after", 0, 32'h99, 1'b0);
        tick();
        #1;
        chk_rf("t4_ret", 1'b1, 5'd4, 32'h44);
        tick();
        #1;
        chk("t4_end", 32'(bus.rf_rd_e), 32'd0);

        // 5: stall holds two pending entries for 4 cycles
        drive(1'b1, 5'd8, 32'h80);
        tick();
        drive(1'b1, 5'd9, 32'h90);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        tick();
        #1;
        chk_rf("t5_pre", 1'b1, 5'd8, 32'h80);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 5'd10, 32'h100);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t5_st%0d_e", c), 32'(bus.rf_rd_e), 32'd0);
            chk($sformatf("t5_st%0d_pend", c), 32'(bus.pend_cnt), 32'd2);
            tick();
        end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        #1;
        chk_rf("t5_r8", 1'b1, 5'd8, 32'h80);
        chk("t5_r8_pend", 32'(bus.pend_cnt), 32'd2);
        tick();
        #1;
        chk_rf("t5_r9", 1'b1, 5'd9, 32'h90);
        chk("t5_r9_pend", 32'(bus.pend_cnt), 32'd1);
        tick();
        #1;
        chk("t5_end_e", 32'(bus.rf_rd_e), 32'd0);
        chk("t5_end_pend", 32'(bus.pend_cnt), 32'd0);

        // 6: asynchronous reset with three entries in flight
        drive(1'b1, 5'd11, 32'hB1);
        tick();
        drive(1'b1, 5'd12, 32'hC1);
        tick();
        drive(1'b1, 5'd13, 32'hD1);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd12, 32'h12);
        #1;
        chk("t6_pend3", 32'(bus.pend_cnt), 32'd3);
        chk_rf("t6_pre", 1'b1, 5'd11, 32'hB1);
        rstn = 1'b0;
        #1;
        chk_rf("t6_rst", 1'b0, 5'd0, 32'h0);
        chk("t6_rst_pend", 32'(bus.pend_cnt), 32'd0);
        chk_fwd("t6_rst", 0, 32'h12, 1'b0);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk($sformatf("t6_post%0d_e", c), 32'(bus.rf_rd_e), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
